// File: rtl/pipe_flow_ctrl_pkg.sv
// Shared flow-command codes, FSM encodings and command bundle
// for the pipeline flow controller.
package pipe_flow_ctrl_pkg;

  localparam int FLOW_WIDTH     = 2;
  localparam int REG_ADDR_WIDTH = 5;

  typedef logic [FLOW_WIDTH-1:0] flow_t;

  localparam flow_t FLOW_WORK    = 2'd0;
  localparam flow_t FLOW_STOP    = 2'd1;
  localparam flow_t FLOW_REFRESH = 2'd2;

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_MC_WAIT = 2'd1;
  localparam logic [1:0] ST_TRAP    = 2'd2;

  typedef struct packed {
    flow_t pc;
    flow_t id;
    flow_t ex;
    flow_t mem;
  } flow_cmd_t;

  function automatic flow_cmd_t flow_cmd(
    input flow_t pc,
    input flow_t id,
    input flow_t ex,
    input flow_t mem
  );
    flow_cmd_t c;
    c.pc  = pc;
    c.id  = id;
    c.ex  = ex;
    c.mem = mem;
    return c;
  endfunction

endpackage

// File: rtl/pipe_flow_ctrl_hazard_det.sv
// Load-use hazard compare between the ID sources and
// the destination of a load sitting in EX.
module pipe_flow_ctrl_hazard_det
  import pipe_flow_ctrl_pkg::*;
(
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_i,
  input  logic                      id_rs1_use_i,
  input  logic                      id_rs2_use_i,
  input  logic                      ex_load_i,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd_i,
  output logic                      hazard_o
);

  logic w_m1;
  logic w_m2;

  assign w_m1 = id_rs1_use_i && (id_rs1_i == ex_rd_i);
  assign w_m2 = id_rs2_use_i && (id_rs2_i == ex_rd_i);

  // x0 is never written, so a load to x0 cannot create a hazard
  assign hazard_o = ex_load_i && (ex_rd_i != '0)
                 && (w_m1 || w_m2);

endmodule

// File: rtl/pipe_flow_ctrl.sv
// Per-register flow command generator (RUN/MC_WAIT/TRAP).
// Optional stall counter: define FLOW_STALL_CNT_EN.
module pipe_flow_ctrl
  import pipe_flow_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int MC_TIMEOUT   = 64,
  parameter int CNT_W        = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_i,
  input  logic                      id_rs1_use_i,
  input  logic                      id_rs2_use_i,
  input  logic                      ex_load_i,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd_i,
  input  logic                      ex_redirect_i,
  input  logic                      ex_mc_start_i,
  input  logic                      ex_mc_done_i,
  input  logic                      trap_req_i,
  output logic [FLOW_WIDTH-1:0]     flow_pc_o,
  output logic [FLOW_WIDTH-1:0]     flow_id_o,
  output logic [FLOW_WIDTH-1:0]     flow_ex_o,
  output logic [FLOW_WIDTH-1:0]     flow_mem_o,
  output logic                      trap_ack_o,
  output logic                      mc_kill_o,
  output logic                      mc_timeout_o,
  output logic [CNT_W-1:0]          stall_cnt_o
);

  localparam int FC_W  = (FLUSH_CYCLES > 1) ?
                         $clog2(FLUSH_CYCLES) : 1;
  localparam int TMR_W = $clog2(MC_TIMEOUT);

  logic [1:0]       r_state;
  logic [TMR_W-1:0] r_tmr;
  logic [FC_W-1:0]  r_fcnt;

  logic [1:0]       w_nxt_state;
  logic [TMR_W-1:0] w_nxt_tmr;
  logic [FC_W-1:0]  w_nxt_fcnt;
  flow_cmd_t        w_cmd;
  logic             w_ack;
  logic             w_kill;
  logic             w_tmo;
  logic             w_hazard;
  logic             w_flush_last;
  logic             w_tmr_last;

  pipe_flow_ctrl_hazard_det u_hazard (
    .id_rs1_i     (id_rs1_i),
    .id_rs2_i     (id_rs2_i),
    .id_rs1_use_i (id_rs1_use_i),
    .id_rs2_use_i (id_rs2_use_i),
    .ex_load_i    (ex_load_i),
    .ex_rd_i      (ex_rd_i),
    .hazard_o     (w_hazard)
  );

  assign w_flush_last = (r_fcnt == '0);
  assign w_tmr_last   = (r_tmr == TMR_W'(MC_TIMEOUT - 1));

  always_comb begin
    w_cmd = flow_cmd(FLOW_WORK, FLOW_WORK,
                     FLOW_WORK, FLOW_WORK);
    w_nxt_state = r_state;
    w_nxt_tmr   = r_tmr;
    w_nxt_fcnt  = r_fcnt;
    w_ack  = 1'b0;
    w_kill = 1'b0;
    w_tmo  = 1'b0;
    if (!rst_n) begin
      w_cmd = flow_cmd(FLOW_REFRESH, FLOW_REFRESH,
                       FLOW_REFRESH, FLOW_REFRESH);
    end else if (r_state != ST_TRAP && trap_req_i) begin
      w_cmd = flow_cmd(FLOW_STOP, FLOW_REFRESH,
                       FLOW_REFRESH, FLOW_REFRESH);
      w_ack       = 1'b1;
      w_kill      = (r_state == ST_MC_WAIT);
      w_nxt_state = ST_TRAP;
      w_nxt_fcnt  = FC_W'(FLUSH_CYCLES - 1);
    end else begin
      unique case (r_state)
        ST_TRAP: begin
          // PC loads the trap vector on the last flush cycle
          w_cmd = flow_cmd(
            w_flush_last ? FLOW_WORK : FLOW_STOP,
            FLOW_REFRESH, FLOW_REFRESH, FLOW_REFRESH);
          if (w_flush_last) w_nxt_state = ST_RUN;
          else w_nxt_fcnt = r_fcnt - 1'b1;
        end
        ST_MC_WAIT: begin
          if (ex_mc_done_i) begin
            w_nxt_state = ST_RUN;
          end else if (w_tmr_last) begin
            w_cmd = flow_cmd(FLOW_STOP, FLOW_STOP,
                             FLOW_REFRESH, FLOW_STOP);
            w_kill      = 1'b1;
            w_tmo       = 1'b1;
            w_nxt_state = ST_RUN;
          end else begin
            w_cmd = flow_cmd(FLOW_STOP, FLOW_STOP,
                             FLOW_STOP, FLOW_REFRESH);
            w_nxt_tmr = r_tmr + 1'b1;
          end
        end
        default: begin
          if (ex_redirect_i) begin
            w_cmd = flow_cmd(FLOW_WORK, FLOW_REFRESH,
                             FLOW_REFRESH, FLOW_WORK);
          end else if (ex_mc_start_i) begin
            if (!ex_mc_done_i) begin
              w_cmd = flow_cmd(FLOW_STOP, FLOW_STOP,
                               FLOW_STOP, FLOW_REFRESH);
              w_nxt_state = ST_MC_WAIT;
              w_nxt_tmr   = '0;
            end
          end else if (w_hazard) begin
            w_cmd = flow_cmd(FLOW_STOP, FLOW_STOP,
                             FLOW_REFRESH, FLOW_WORK);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_tmr   <= '0;
      r_fcnt  <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_tmr   <= w_nxt_tmr;
      r_fcnt  <= w_nxt_fcnt;
    end
  end

  assign flow_pc_o    = w_cmd.pc;
  assign flow_id_o    = w_cmd.id;
  assign flow_ex_o    = w_cmd.ex;
  assign flow_mem_o   = w_cmd.mem;
  assign trap_ack_o   = w_ack;
  assign mc_kill_o    = w_kill;
  assign mc_timeout_o = w_tmo;

`ifdef FLOW_STALL_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_cmd.pc == FLOW_STOP
                 && r_stall_cnt != '1) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Self-checking bench: vector table, directed corner
// sequences and random stimulus against a cycle model.
module tb_pipe_flow_ctrl;
  import pipe_flow_ctrl_pkg::*;

  localparam int FC = 2;
  localparam int MT = 8;
  localparam int CW = 32;
`ifdef FLOW_STALL_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  localparam flow_t W = FLOW_WORK;
  localparam flow_t S = FLOW_STOP;
  localparam flow_t R = FLOW_REFRESH;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] rs1, rs2, rd;
  logic u1, u2, load, redir, st, dn, trap;
  flow_t pc_o, id_o, ex_o, mem_o;
  logic ack_o, kill_o, tmo_o;
  logic [CW-1:0] cnt_o;

  pipe_flow_ctrl #(
    .FLUSH_CYCLES (FC),
    .MC_TIMEOUT   (MT),
    .CNT_W        (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_rs1_i      (rs1),
    .id_rs2_i      (rs2),
    .id_rs1_use_i  (u1),
    .id_rs2_use_i  (u2),
    .ex_load_i     (load),
    .ex_rd_i       (rd),
    .ex_redirect_i (redir),
    .ex_mc_start_i (st),
    .ex_mc_done_i  (dn),
    .trap_req_i    (trap),
    .flow_pc_o     (pc_o),
    .flow_id_o     (id_o),
    .flow_ex_o     (ex_o),
    .flow_mem_o    (mem_o),
    .trap_ack_o    (ack_o),
    .mc_kill_o     (kill_o),
    .mc_timeout_o  (tmo_o),
    .stall_cnt_o   (cnt_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic       load;
    logic [4:0] rd, rs1, rs2;
    logic       u1, u2, redir, st, dn;
    logic [7:0] exp;
  } vec_t;

  vec_t tv[10];

  bit      m_wait;
  int      m_wcnt;
  int      m_trap;
  longint  m_stall;

  function automatic logic [7:0] f4(
    flow_t p, flow_t i, flow_t x, flow_t m);
    return {p, i, x, m};
  endfunction

  function automatic logic [10:0] pk(
    logic [7:0] f, logic a, logic k, logic t);
    return {f, a, k, t};
  endfunction

  task automatic chk(string nm, logic [10:0] exp);
    logic [10:0] act;
    act = {pc_o, id_o, ex_o, mem_o, ack_o, kill_o, tmo_o};
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic chk_cnt(string nm, longint n);
    logic [CW-1:0] exp;
    exp = CNT_ON ? CW'(n) : '0;
    n_chk++;
    if (cnt_o === exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", nm, cnt_o, exp);
  endtask

  task automatic clr_in();
    {load, redir, st, dn, trap, u1, u2} = '0;
    rd = '0; rs1 = '0; rs2 = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clr_in();
    #1 chk("rst_flow", pk(f4(R, R, R, R), 0, 0, 0));
    chk_cnt("rst_cnt", 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_wait = 0; m_wcnt = 0; m_trap = 0; m_stall = 0;
  endtask

  // Expected outputs for this cycle, then advance the model
  task automatic model(output logic [10:0] e);
    flow_t p, i, x, m;
    logic a, k, t;
    bit lu;
    lu = load && rd != 0
      && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    p = W; i = W; x = W; m = W;
    a = 0; k = 0; t = 0;
    if (m_trap > 0) begin
      p = (m_trap == 1) ? W : S;
      i = R; x = R; m = R;
      m_trap--;
    end else if (trap) begin
      a = 1; k = m_wait;
      p = S; i = R; x = R; m = R;
      m_wait = 0; m_trap = FC;
    end else if (m_wait) begin
      if (dn) begin
        m_wait = 0;
      end else if (m_wcnt == MT - 1) begin
        k = 1; t = 1;
        p = S; i = S; x = R; m = S;
        m_wait = 0;
      end else begin
        p = S; i = S; x = S; m = R;
        m_wcnt++;
      end
    end else if (redir) begin
      i = R; x = R;
    end else if (st && !dn) begin
      p = S; i = S; x = S; m = R;
      m_wait = 1; m_wcnt = 0;
    end else if (!st && lu) begin
      p = S; i = S; x = R;
    end
    if (p == S) m_stall++;
    e = pk(f4(p, i, x, m), a, k, t);
  endtask

  task automatic cyc(string nm, logic [10:0] exp);
    #1 chk(nm, exp);
    @(negedge clk);
  endtask

  initial begin
    logic [10:0] e;
    rst_n = 1'b0;
    clr_in();
    load = 1; rd = 5; rs1 = 5; u1 = 1; trap = 1;
    #2 chk("rst_hold", pk(f4(R, R, R, R), 0, 0, 0));
    chk_cnt("rst_cnt0", 0);

    tv[0] = '{1, 5, 5, 0, 1, 0, 0, 0, 0, f4(S, S, R, W)};
    tv[1] = '{1, 0, 0, 0, 1, 0, 0, 0, 0, f4(W, W, W, W)};
    tv[2] = '{1, 5, 5, 0, 1, 0, 1, 0, 0, f4(W, R, R, W)};
    tv[3] = '{1, 7, 0, 7, 0, 1, 0, 0, 0, f4(S, S, R, W)};
    tv[4] = '{1, 7, 0, 7, 0, 0, 0, 0, 0, f4(W, W, W, W)};
    tv[5] = '{0, 5, 5, 0, 1, 0, 0, 0, 0, f4(W, W, W, W)};
    tv[6] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, f4(W, W, W, W)};
    tv[7] = '{1, 3, 3, 3, 1, 1, 0, 1, 1, f4(W, W, W, W)};
    tv[8] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, f4(W, R, R, W)};
    tv[9] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, f4(W, W, W, W)};

    do_reset();
    for (int n = 0; n < 10; n++) begin
      load = tv[n].load; rd = tv[n].rd;
      rs1 = tv[n].rs1; rs2 = tv[n].rs2;
      u1 = tv[n].u1; u2 = tv[n].u2;
      redir = tv[n].redir; st = tv[n].st; dn = tv[n].dn;
      cyc($sformatf("vec%0d", n), pk(tv[n].exp, 0, 0, 0));
    end

    // mul/div finishing after four stall cycles
    do_reset();
    st = 1;
    for (int n = 0; n < 4; n++)
      cyc($sformatf("mc_stall%0d", n),
          pk(f4(S, S, S, R), 0, 0, 0));
    dn = 1;
    cyc("mc_done", pk(f4(W, W, W, W), 0, 0, 0));
    st = 0; dn = 0;
    #1 chk_cnt("mc_cnt", 4);
    cyc("mc_after", pk(f4(W, W, W, W), 0, 0, 0));

    // timeout without done
    do_reset();
    st = 1;
    cyc("to_start", pk(f4(S, S, S, R), 0, 0, 0));
    st = 0;
    for (int n = 1; n < MT; n++)
      cyc($sformatf("to_wait%0d", n),
          pk(f4(S, S, S, R), 0, 0, 0));
    cyc("to_abort", pk(f4(S, S, R, S), 0, 1, 1));
    cyc("to_run", pk(f4(W, W, W, W), 0, 0, 0));

    // trap while waiting on a multi-cycle op
    do_reset();
    st = 1;
    cyc("tw_start", pk(f4(S, S, S, R), 0, 0, 0));
    cyc("tw_wait", pk(f4(S, S, S, R), 0, 0, 0));
    trap = 1;
    cyc("tw_entry", pk(f4(S, R, R, R), 1, 1, 0));
    st = 0;
    cyc("tw_flush1", pk(f4(S, R, R, R), 0, 0, 0));
    cyc("tw_flush2", pk(f4(W, R, R, R), 0, 0, 0));
    trap = 0;
    cyc("tw_run", pk(f4(W, W, W, W), 0, 0, 0));

    // async reset in the middle of a trap flush
    do_reset();
    trap = 1;
    cyc("tr_entry", pk(f4(S, R, R, R), 1, 0, 0));
    trap = 0;
    #1 chk("tr_flush1", pk(f4(S, R, R, R), 0, 0, 0));
    #2 rst_n = 1'b0;
    #1 chk("tr_rst", pk(f4(R, R, R, R), 0, 0, 0));
    chk_cnt("tr_rst_cnt", 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc("tr_run", pk(f4(W, W, W, W), 0, 0, 0));

    do_reset();
    for (int n = 0; n < 3000; n++) begin
      load  = $urandom_range(0, 1);
      rd    = 5'($urandom_range(0, 7));
      rs1   = 5'($urandom_range(0, 7));
      rs2   = 5'($urandom_range(0, 7));
      u1    = $urandom_range(0, 1);
      u2    = $urandom_range(0, 1);
      redir = ($urandom_range(0, 7) == 0);
      st    = ($urandom_range(0, 4) == 0);
      dn    = ($urandom_range(0, 5) == 0);
      trap  = ($urandom_range(0, 39) == 0);
      #1 model(e);
      chk($sformatf("rnd%0d", n), e);
      @(negedge clk);
    end
    #1 chk_cnt("rnd_cnt", m_stall);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
